// File: rtl/conv_k_addr_gen.sv
// rtl/conv_k_addr_gen.sv - multi-port convolution kernel weight read-address sequencer
// Walks elem -> pass -> kernel counters and presents one address per port each cycle.
module conv_k_addr_gen #(
  parameter int ADDR_W      = 8,
  parameter int NUM_PORTS   = 2,
  parameter int KSIZE       = 25,
  parameter int PORT_STRIDE = 75,
  parameter int REPEAT      = 64,
  parameter int NUM_KERNELS = 3,
  parameter int LEAD_CYCLES = 0,
  localparam int KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stall,
  output logic [NUM_PORTS*ADDR_W-1:0] addr,
  output logic                        addr_valid,
  output logic [KW-1:0]               kern_idx,
  output logic                        last_elem,
  output logic                        busy,
  output logic                        done
);

  localparam int EW        = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int PW        = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int LW        = (LEAD_CYCLES > 1) ? $clog2(LEAD_CYCLES) : 1;
  localparam int LEAD_LAST = (LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [EW-1:0] r_elem;
  logic [PW-1:0] r_pass;
  logic [KW-1:0] r_kern;
  logic [LW-1:0] r_lead;

  logic w_elem_last, w_pass_last, w_kern_last, w_lead_last, w_advance;

  assign w_elem_last = (r_elem == EW'(KSIZE - 1));
  assign w_pass_last = (r_pass == PW'(REPEAT - 1));
  assign w_kern_last = (r_kern == KW'(NUM_KERNELS - 1));
  assign w_lead_last = (r_lead == LW'(LEAD_LAST));
  assign w_advance   = (r_state == RUN) && !stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = (LEAD_CYCLES > 0) ? PRIME : RUN;
      PRIME:      if (w_lead_last) w_state_nxt = RUN;
      RUN:        if (w_advance && w_elem_last && w_pass_last && w_kern_last) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Counters only move on an issued address, so a stall replays nothing and skips nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_elem <= '0;
      r_pass <= '0;
      r_kern <= '0;
      r_lead <= '0;
    end else if ((r_state == IDLE || r_state == DONE) && start) begin
      r_elem <= '0;
      r_pass <= '0;
      r_kern <= '0;
      r_lead <= '0;
    end else if (r_state == PRIME) begin
      r_lead <= r_lead + 1'b1;
    end else if (w_advance) begin
      if (!w_elem_last) begin
        r_elem <= r_elem + 1'b1;
      end else begin
        r_elem <= '0;
        if (!w_pass_last) begin
          r_pass <= r_pass + 1'b1;
        end else begin
          r_pass <= '0;
          if (!w_kern_last) r_kern <= r_kern + 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign addr[p*ADDR_W +: ADDR_W] =
      ADDR_W'(p * PORT_STRIDE + KSIZE * int'(r_kern) + int'(r_elem));
  end

  assign addr_valid = w_advance;
  assign last_elem  = w_advance && w_elem_last;
  assign kern_idx   = r_kern;
  assign busy       = (r_state == PRIME) || (r_state == RUN);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_conv_k_addr_gen.sv
// tb/tb_conv_k_addr_gen.sv - directed and table-driven checks of conv_k_addr_gen
module tb_conv_k_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance, plus an ADDR_W=6 twin sharing its inputs
  logic        a_reset, a_start, a_stall;
  logic [15:0] a_addr;
  logic        a_valid, a_last, a_busy, a_done;
  logic [1:0]  a_kern;
  logic [11:0] c_addr;
  logic        c_valid, c_last, c_busy, c_done;
  logic [1:0]  c_kern;

  // Small instance with a lead-in
  logic        b_reset, b_start, b_stall;
  logic [15:0] b_addr;
  logic        b_valid, b_last, b_busy, b_done;
  logic [0:0]  b_kern;

  conv_k_addr_gen dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .stall(a_stall),
    .addr(a_addr), .addr_valid(a_valid), .kern_idx(a_kern),
    .last_elem(a_last), .busy(a_busy), .done(a_done)
  );

  conv_k_addr_gen #(.ADDR_W(6)) dut_c (
    .clk(clk), .reset(a_reset), .start(a_start), .stall(a_stall),
    .addr(c_addr), .addr_valid(c_valid), .kern_idx(c_kern),
    .last_elem(c_last), .busy(c_busy), .done(c_done)
  );

  conv_k_addr_gen #(.KSIZE(4), .REPEAT(2), .NUM_KERNELS(2), .LEAD_CYCLES(3)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .stall(b_stall),
    .addr(b_addr), .addr_valid(b_valid), .kern_idx(b_kern),
    .last_elem(b_last), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Called on a negedge; drives a start pulse and scoreboards the default
  // instance until stop_at addresses are issued. Leaves on a negedge.
  task automatic a_seq(input int stall_at, input int start_at, input int stop_at, output int cyc);
    int i, st, k, e;
    logic stall_now;
    logic [7:0] e0, e1;
    i = 0; st = 0; cyc = 0;
    a_start = 1'b1;
    @(negedge clk);
    while (i < stop_at && cyc < 6000) begin
      a_start   = (cyc == start_at);
      stall_now = (i == stall_at) && (st < 5);
      a_stall   = stall_now;
      #1;
      k  = i / 1600;
      e  = i % 25;
      e0 = 8'(k * 25 + e);
      e1 = 8'(k * 25 + e + 75);
      chk("a_out", 64'({a_valid, a_last, a_busy, a_done, a_kern, a_addr}),
          64'({!stall_now, !stall_now && (e == 24), 1'b1, 1'b0, 2'(k), e1, e0}));
      chk("c_addr", 64'({c_valid, c_addr}), 64'({!stall_now, e1[5:0], e0[5:0]}));
      if (i == 4799 && !stall_now) chk("c_wrap_addr1", 64'(c_addr[11:6]), 64'd21);
      if (stall_now) st++; else i++;
      @(negedge clk);
      cyc++;
    end
    a_start = 1'b0;
    a_stall = 1'b0;
  endtask

  typedef struct {
    logic       start, stall;
    logic       valid, last, busy, done;
    logic       kern;
    logic [7:0] a0;
    logic       chk_addr;
  } vec_t;

  vec_t tbl [20];
  int   b_seq [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;

    // PRIME: a start and a stall arriving here must both be ignored
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    for (int k = 0; k < 16; k++)
      tbl[3+k] = '{1'b0, 1'b0, 1'b1, (k % 4 == 3), 1'b1, 1'b0, (k >= 8), 8'(b_seq[k]), 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};

    a_reset = 1'b0; a_start = 1'b0; a_stall = 1'b0;
    b_reset = 1'b0; b_start = 1'b0; b_stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("a_reset", 64'({a_valid, a_last, a_busy, a_done, a_kern, a_addr}),
        64'({1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd75, 8'd0}));
    chk("c_reset", 64'(c_addr), 64'({6'd11, 6'd0}));
    chk("b_reset", 64'({b_valid, b_last, b_busy, b_done, b_kern, b_addr}),
        64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd75, 8'd0}));
    a_reset = 1'b1; b_reset = 1'b1;
    @(negedge clk);

    // Full default sequence: 5-cycle stall at addr0=12, stray start mid-run
    a_seq(12, 100, 4800, cyc);
    chk("a_cycles_stalled", 64'(cyc), 64'd4805);
    #1;
    chk("a_done1", 64'({a_valid, a_busy, a_done}), 64'({1'b0, 1'b0, 1'b1}));
    @(negedge clk);

    // Start from DONE reruns from zero; done must drop on the first cycle
    a_seq(-1, -1, 4800, cyc);
    chk("a_cycles", 64'(cyc), 64'd4800);
    #1;
    chk("a_done2", 64'({a_valid, a_busy, a_done}), 64'({1'b0, 1'b0, 1'b1}));
    @(negedge clk);

    // Reset while addr0=30, with start held alongside reset
    a_seq(-1, -1, 1605, cyc);
    #1;
    chk("a_pre_abort", 64'({a_valid, a_addr[7:0]}), 64'({1'b1, 8'd30}));
    a_reset = 1'b0; a_start = 1'b1;
    @(negedge clk);
    #1;
    chk("a_abort", 64'({a_valid, a_busy, a_done, a_kern, a_addr}),
        64'({1'b0, 1'b0, 1'b0, 2'd0, 8'd75, 8'd0}));
    chk("c_abort", 64'(c_addr), 64'({6'd11, 6'd0}));
    a_reset = 1'b1; a_start = 1'b0;
    @(negedge clk);
    #1;
    chk("a_start_in_reset", 64'({a_valid, a_busy, a_done}), 64'd0);
    @(negedge clk);
    a_seq(-1, -1, 3, cyc);

    // Lead-in instance, table-driven
    b_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      b_start = tbl[k].start;
      b_stall = tbl[k].stall;
      #1;
      chk($sformatf("b_ctl[%0d]", k), 64'({b_valid, b_last, b_busy, b_done}),
          64'({tbl[k].valid, tbl[k].last, tbl[k].busy, tbl[k].done}));
      if (tbl[k].chk_addr)
        chk($sformatf("b_addr[%0d]", k), 64'({b_kern, b_addr}),
            64'({tbl[k].kern, 8'(tbl[k].a0 + 8'd75), tbl[k].a0}));
      @(negedge clk);
    end
    b_start = 1'b0; b_stall = 1'b0;
    #1;
    chk("b_done_hold", 64'({b_busy, b_done}), 64'({1'b0, 1'b1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
